avalon_ram_slave: RTL and testbench

AVALON_RAM_SLAVE -- requirements
Module: avalon_ram_slave

---
 rtl/avalon_ram_slave.sv | 138 +++++++++++++
 tb/tb_avalon_ram_slave.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_ram_slave.sv
// rtl/avalon_ram_slave.sv - Avalon-MM word RAM slave with wait injection, read pipeline, error flags and counters
module avalon_ram_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 0
) (
    input  logic                    AVR_Clk,
    input  logic                    AVR_Reset,
    input  logic [ADDR_WIDTH-1:0]   AVR_s0_address,
    input  logic                    AVR_s0_read,
    input  logic                    AVR_s0_write,
    input  logic [DATA_WIDTH-1:0]   AVR_s0_writedata,
    input  logic [DATA_WIDTH/8-1:0] AVR_s0_byteenable,
    output logic [DATA_WIDTH-1:0]   AVR_s0_readdata,
    output logic                    AVR_s0_readdatavalid,
    output logic                    AVR_s0_waitrequest,
    output logic                    AVR_Err_Range,
    output logic                    AVR_Err_Protocol,
    output logic [31:0]             AVR_Rd_Count,
    output logic [31:0]             AVR_Wr_Count
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, STALL} state_t;

    state_t state;
    logic [3:0] cnt;

    logic req, in_range, accept, wr_acc, rd_acc, rw_clash, drop;
    logic [IDX_W-1:0] idx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [READ_LATENCY-1:0] pv;
    logic [DATA_WIDTH-1:0] pd [READ_LATENCY];

    assign req      = AVR_s0_read | AVR_s0_write;
    assign in_range = {1'b0, AVR_s0_address} < DEPTH_L;
    assign idx      = AVR_s0_address[IDX_W-1:0];

    // The stall is raised combinationally so a fresh request is held off in the cycle it appears.
    always_comb begin
        AVR_s0_waitrequest = 1'b0;
        if (WAIT_L != 4'd0 && !AVR_Reset) begin
            if (state == IDLE)
                AVR_s0_waitrequest = req;
            else
                AVR_s0_waitrequest = (cnt < WAIT_L);
        end
    end

    assign accept   = req && !AVR_s0_waitrequest && !AVR_Reset;
    assign wr_acc   = accept && AVR_s0_write;
    assign rd_acc   = accept && AVR_s0_read && !AVR_s0_write;
    assign rw_clash = accept && AVR_s0_read && AVR_s0_write;
    assign drop     = (state == STALL) && !req && !AVR_Reset;

    always_ff @(posedge AVR_Clk or posedge AVR_Reset) begin
        if (AVR_Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && WAIT_L != 4'd0) begin
                        state <= STALL;
                        cnt   <= 4'd1;
                    end
                end
                STALL: begin
                    if (!req || cnt >= WAIT_L) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Storage has no reset so contents survive AVR_Reset.
    always_ff @(posedge AVR_Clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (AVR_s0_byteenable[b])
                    mem[idx][b*8 +: 8] <= AVR_s0_writedata[b*8 +: 8];
            end
        end
    end

    // Each stage loads data only alongside a valid, so the last stage holds the previous result.
    always_ff @(posedge AVR_Clk or posedge AVR_Reset) begin
        if (AVR_Reset) begin
            pv <= '0;
            for (int i = 0; i < READ_LATENCY; i++)
                pd[i] <= '0;
        end else begin
            pv[0] <= rd_acc;
            if (rd_acc)
                pd[0] <= in_range ? mem[idx] : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1])
                    pd[i] <= pd[i-1];
            end
        end
    end

    assign AVR_s0_readdatavalid = pv[READ_LATENCY-1];
    assign AVR_s0_readdata      = pd[READ_LATENCY-1];

    always_ff @(posedge AVR_Clk or posedge AVR_Reset) begin
        if (AVR_Reset) begin
            AVR_Err_Range    <= 1'b0;
            AVR_Err_Protocol <= 1'b0;
            AVR_Rd_Count     <= 32'd0;
            AVR_Wr_Count     <= 32'd0;
        end else begin
            if (accept && !in_range)
                AVR_Err_Range <= 1'b1;
            if (rw_clash || drop)
                AVR_Err_Protocol <= 1'b1;
            if (rd_acc && AVR_Rd_Count != 32'hFFFF_FFFF)
                AVR_Rd_Count <= AVR_Rd_Count + 32'd1;
            if (wr_acc && AVR_Wr_Count != 32'hFFFF_FFFF)
                AVR_Wr_Count <= AVR_Wr_Count + 32'd1;
        end
    end
endmodule

// File: tb/tb_avalon_ram_slave.sv
// tb/tb_avalon_ram_slave.sv - scoreboard bench for avalon_ram_slave
module tb_avalon_ram_slave;
    localparam int AW = 16;
    localparam int L0 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [AW-1:0] a0, a1;
    logic r0, w0, r1, w1;
    logic [31:0] wd0, wd1;
    logic [3:0] be0, be1;
    logic [31:0] rd0, rd1, rc0, wc0, rc1, wc1;
    logic rv0, wq0, er0, ep0, rv1, wq1, er1, ep1;

    avalon_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(16), .READ_LATENCY(L0), .WAIT_CYCLES(0)) dut0 (
        .AVR_Clk(clk), .AVR_Reset(rst), .AVR_s0_address(a0), .AVR_s0_read(r0), .AVR_s0_write(w0),
        .AVR_s0_writedata(wd0), .AVR_s0_byteenable(be0), .AVR_s0_readdata(rd0),
        .AVR_s0_readdatavalid(rv0), .AVR_s0_waitrequest(wq0), .AVR_Err_Range(er0),
        .AVR_Err_Protocol(ep0), .AVR_Rd_Count(rc0), .AVR_Wr_Count(wc0));

    avalon_ram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(16), .READ_LATENCY(1), .WAIT_CYCLES(3)) dut1 (
        .AVR_Clk(clk), .AVR_Reset(rst), .AVR_s0_address(a1), .AVR_s0_read(r1), .AVR_s0_write(w1),
        .AVR_s0_writedata(wd1), .AVR_s0_byteenable(be1), .AVR_s0_readdata(rd1),
        .AVR_s0_readdatavalid(rv1), .AVR_s0_waitrequest(wq1), .AVR_Err_Range(er1),
        .AVR_Err_Protocol(ep1), .AVR_Rd_Count(rc1), .AVR_Wr_Count(wc1));

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    logic [31:0] q1[$];
    exp_t m_e;
    logic [31:0] m_d;
    int edges = 0;
    int n_checks = 0;
    int n_fail = 0;
    int exp_rd = 0;
    logic [31:0] exp_wr = 32'd0;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rv0) begin
            if (q0.size() == 0) begin
                check("d0 spurious readdatavalid", {31'd0, rv0}, 32'd0);
            end else begin
                m_e = q0.pop_front();
                check("d0 readdata", rd0, m_e.data);
                check("d0 read latency", edges, m_e.due);
            end
        end
        if (rv1) begin
            if (q1.size() == 0) begin
                check("d1 spurious readdatavalid", {31'd0, rv1}, 32'd0);
            end else begin
                m_d = q1.pop_front();
                check("d1 readdata", rd1, m_d);
            end
        end
    end

    task automatic wr0t(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        r0 = 1'b0; w0 = 1'b1; a0 = addr; wd0 = data; be0 = be;
        if (exp_wr != 32'hFFFF_FFFF) exp_wr = exp_wr + 32'd1;
    endtask

    task automatic rd0t(input logic [AW-1:0] addr, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        r0 = 1'b1; w0 = 1'b0; a0 = addr;
        e.data = exp; e.due = edges + L0;
        q0.push_back(e);
        exp_rd++;
    endtask

    task automatic idle0(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            r0 = 1'b0; w0 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        exp_t e;
        rst = 1'b1;
        r0 = 0; w0 = 0; a0 = '0; wd0 = '0; be0 = '0;
        r1 = 0; w1 = 0; a1 = '0; wd1 = '0; be1 = '0;
        repeat (3) @(negedge clk);
        check("reset readdatavalid", {31'd0, rv0}, 32'd0);
        check("reset readdata", rd0, 32'd0);
        check("reset waitrequest d1", {31'd0, wq1}, 32'd0);
        check("reset err flags", {30'd0, er0, ep0}, 32'd0);
        check("reset rd_count", rc0, 32'd0);
        check("reset wr_count", wc0, 32'd0);
        rst = 1'b0;

        wr0t(5, 32'hDEAD_BEEF, 4'hF);
        rd0t(5, 32'hDEAD_BEEF);
        idle0(3);
        check("raw rd_count", rc0, 32'd1);
        check("raw wr_count", wc0, 32'd1);

        wr0t(0, 32'h1122_3344, 4'hF);
        wr0t(0, 32'hAABB_CCDD, 4'b0101);
        rd0t(0, 32'h11BB_33DD);
        wr0t(5, 32'h0000_0000, 4'b0000);
        rd0t(5, 32'hDEAD_BEEF);
        rd0t(0, 32'h11BB_33DD);
        rd0t(5, 32'hDEAD_BEEF);
        idle0(4);
        check("lanes rd_count", rc0, exp_rd);
        check("lanes wr_count", wc0, exp_wr);
        check("no errors yet", {30'd0, er0, ep0}, 32'd0);
        check("readdata hold", rd0, 32'hDEAD_BEEF);
        check("waitrequest d0", {31'd0, wq0}, 32'd0);

        wr0t(16, 32'h1234_5678, 4'hF);
        idle0(1);
        check("range write flag", {31'd0, er0}, 32'd1);
        rd0t(16, 32'h0000_0000);
        rd0t(5, 32'hDEAD_BEEF);
        idle0(4);

        check("protocol flag clear", {31'd0, ep0}, 32'd0);
        @(negedge clk);
        r0 = 1'b1; w0 = 1'b1; a0 = 2; wd0 = 32'hCAFE_F00D; be0 = 4'hF;
        exp_wr = exp_wr + 32'd1;
        idle0(1);
        check("protocol flag set", {31'd0, ep0}, 32'd1);
        rd0t(2, 32'hCAFE_F00D);
        idle0(4);
        check("final rd_count", rc0, exp_rd);
        check("final wr_count", wc0, exp_wr);

        @(negedge clk);
        r0 = 1'b1; w0 = 1'b0; a0 = 5;
        @(negedge clk);
        a0 = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        r0 = 1'b0;
        exp_rd = 0;
        exp_wr = 32'd0;
        @(negedge clk);
        check("midreset readdatavalid", {31'd0, rv0}, 32'd0);
        check("midreset counters", rc0 | wc0, 32'd0);
        check("midreset flags", {30'd0, er0, ep0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        r0 = 1'b1; a0 = 5;
        e.data = 32'hDEAD_BEEF; e.due = edges + L0;
        q0.push_back(e);
        exp_rd++;
        idle0(4);
        check("post reset rd_count", rc0, 32'd1);

        @(negedge clk);
        force dut0.AVR_Wr_Count = 32'hFFFF_FFFE;
        #1;
        release dut0.AVR_Wr_Count;
        for (int n = 0; n < 3; n++) begin
            wr0t(1, n, 4'hF);
            idle0(1);
            check("saturated wr_count", wc0, 32'hFFFF_FFFF);
        end

        @(negedge clk);
        w1 = 1'b1; a1 = 3; wd1 = 32'h5A5A_1234; be1 = 4'hF;
        #1;
        check("stall cycle 1", {31'd0, wq1}, 32'd1);
        @(negedge clk);
        check("stall cycle 2", {31'd0, wq1}, 32'd1);
        @(negedge clk);
        check("stall cycle 3", {31'd0, wq1}, 32'd1);
        @(negedge clk);
        check("stall release", {31'd0, wq1}, 32'd0);
        check("wr_count before accept", wc1, 32'd0);
        @(negedge clk);
        w1 = 1'b0;
        check("wr_count after accept", wc1, 32'd1);
        #1;
        check("idle waitrequest", {31'd0, wq1}, 32'd0);

        @(negedge clk);
        r1 = 1'b1; a1 = 3;
        q1.push_back(32'h5A5A_1234);
        #1;
        k = 0;
        while (wq1 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("d1 read stall cycles", k, 3);
        @(negedge clk);
        r1 = 1'b0;
        @(negedge clk);
        r1 = 1'b1; a1 = 3;
        @(negedge clk);
        r1 = 1'b0;
        @(negedge clk);
        check("drop protocol flag", {31'd0, ep1}, 32'd1);
        check("drop rd_count", rc1, 32'd1);

        repeat (5) @(negedge clk);
        check("d0 queue drained", q0.size(), 32'd0);
        check("d1 queue drained", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
